// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding AXI-style read of the next instruction,
// held for decode until accepted, with redirect/kill handling for in-flight reads.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        REQ    = 2'b00,
        WAIT_R = 2'b01,
        HOLD   = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_pending_q, pc_pending_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fetch_err_q, fetch_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            pc_pending_q <= RESET_PC;
            kill_q       <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_pending_q <= pc_pending_d;
            kill_q       <= kill_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_pending_d = pc_pending_q;
        kill_d       = kill_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_err_d  = fetch_err_q;
        arvalid      = 1'b0;
        rready       = 1'b0;
        inst_valid   = 1'b0;

        case (state_q)
            REQ: begin
                // araddr must stay on pc until the handshake, so a redirect is parked in pc_pending
                arvalid = 1'b1;
                if (redirect_valid) begin
                    kill_d       = 1'b1;
                    pc_pending_d = redirect_pc;
                end
                if (arready) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (redirect_valid) begin
                        state_d = REQ;
                        pc_d    = redirect_pc;
                        kill_d  = 1'b0;
                    end else if (kill_q) begin
                        state_d = REQ;
                        pc_d    = pc_pending_q;
                        kill_d  = 1'b0;
                    end else begin
                        state_d     = HOLD;
                        inst_d      = rdata;
                        inst_pc_d   = pc_q;
                        fetch_err_d = (rresp != 2'b00);
                    end
                end else if (redirect_valid) begin
                    kill_d       = 1'b1;
                    pc_pending_d = redirect_pc;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (redirect_valid) begin
                    state_d = REQ;
                    pc_d    = redirect_pc;
                end else if (inst_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (rst) begin
            arvalid    = 1'b0;
            rready     = 1'b0;
            inst_valid = 1'b0;
        end
    end

    assign araddr    = pc_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: behavioural instruction memory plus a scoreboard of
// expected {inst, pc, err} entries pushed as fetches are set up and popped on inst_valid.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .fetch_err(fetch_err), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] exp_pc;

    // Memory model: rvalid appears mem_delay cycles after the cycle following the handshake.
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int unsigned mem_cnt = 0;
    int unsigned mem_delay = 0;
    int unsigned overlap_cnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a - 32'h8000_0000) ^ 32'h0000_0413;
    endfunction

    assign rvalid = mem_pend && (mem_cnt == 0);
    assign rdata  = rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    assign rresp  = (rvalid && err_en && mem_addr == err_addr) ? 2'b10 : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            mem_pend <= 1'b0;
            mem_cnt  <= 0;
        end else if (arvalid && arready) begin
            if (mem_pend) overlap_cnt <= overlap_cnt + 1;
            mem_pend <= 1'b1;
            mem_addr <= araddr;
            mem_cnt  <= mem_delay;
        end else if (rvalid && rready) begin
            mem_pend <= 1'b0;
        end else if (mem_pend && mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int unsigned budget, output int unsigned cycles, output bit ok);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!inst_valid && cycles < budget);
        ok = inst_valid;
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++;
        if ({arvalid, rready, inst_valid, inst, inst_pc, fetch_err} !== '0)
            $display("FAIL reset_state: got %b%b%b %h %h %b want all zero",
                     arvalid, rready, inst_valid, inst, inst_pc, fetch_err);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, RST_PC})
            $display("FAIL first_fetch: got %b %h want 1 %h", arvalid, araddr, RST_PC);
        else n_pass++;
    endtask

    task automatic test_basic();
        int unsigned cyc;
        bit ok;
        exp_t e;
        exp_pc = RST_PC;
        sb_q.push_back('{inst: 32'h0000_0413, pc: 32'h8000_0000, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL basic_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL basic_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        n_checks++;
        if (cyc != 2) $display("FAIL basic_latency: got %0d want 2", cyc);
        else n_pass++;
        n_checks++;
        if ({arvalid, rready} !== 2'b00) $display("FAIL hold_exclusive: got %b%b want 00", arvalid, rready);
        else n_pass++;
        step();
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0004})
            $display("FAIL basic_next: got %b %h want 1 80000004", arvalid, araddr);
        else n_pass++;
        exp_pc = 32'h8000_0004;
    endtask

    task automatic test_throughput();
        int unsigned cyc;
        bit ok;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b0});
            wait_valid(20, cyc, ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok) $display("FAIL tput_timeout: got no inst_valid want inst_valid");
            else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
                $display("FAIL tput_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (cyc != 3) $display("FAIL tput_period: got %0d want 3", cyc);
                else n_pass++;
            end
            exp_pc = exp_pc + 32'd4;
        end
        step();
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, exp_pc})
            $display("FAIL tput_next: got %b %h want 1 %h", arvalid, araddr, exp_pc);
        else n_pass++;
    endtask

    task automatic test_hold_stall();
        int unsigned cyc;
        bit ok;
        exp_t e;
        inst_ready = 1'b0;
        sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL stall_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL stall_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({inst_valid, arvalid, rready, inst, inst_pc} !== {1'b1, 1'b0, 1'b0, e.inst, e.pc})
                $display("FAIL stall_hold: got %b%b%b %h %h want 100 %h %h",
                         inst_valid, arvalid, rready, inst, inst_pc, e.inst, e.pc);
            else n_pass++;
        end
        inst_ready = 1'b1;
        step();
        exp_pc = exp_pc + 32'd4;
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, exp_pc})
            $display("FAIL stall_next: got %b %h want 1 %h", arvalid, araddr, exp_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        int unsigned cyc;
        bit ok;
        exp_t e;
        mem_delay = 1;
        step();
        n_checks++;
        if ({rready, rvalid} !== 2'b10) $display("FAIL rw_wait_state: got %b%b want 10", rready, rvalid);
        else n_pass++;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL rw_no_valid: got %b want 0", inst_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h8000_0100})
            $display("FAIL rw_target: got %b %b %h want 0 1 80000100", inst_valid, arvalid, araddr);
        else n_pass++;
        // redirect landing in the same cycle as the read beat
        mem_delay = 0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h8000_0200})
            $display("FAIL rw_beat_target: got %b %b %h want 0 1 80000200", inst_valid, arvalid, araddr);
        else n_pass++;
        exp_pc = 32'h8000_0200;
        sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL rw_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL rw_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        step();
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_arready_stall();
        int unsigned cyc;
        bit ok;
        exp_t e;
        arready        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({arvalid, araddr} !== {1'b1, exp_pc})
                $display("FAIL ars_stable: got %b %h want 1 %h", arvalid, araddr, exp_pc);
            else n_pass++;
            step();
            redirect_valid = 1'b0;
        end
        arready = 1'b1;
        #1;
        step();
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL ars_no_valid: got %b want 0", inst_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h8000_0300})
            $display("FAIL ars_target: got %b %b %h want 0 1 80000300", inst_valid, arvalid, araddr);
        else n_pass++;
        exp_pc = 32'h8000_0300;
        sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL ars_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL ars_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        step();
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_redirect_multi();
        mem_delay      = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step();
        redirect_pc    = 32'h8000_0500;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0) $display("FAIL rm_no_valid: got %b want 0", inst_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h8000_0500})
            $display("FAIL rm_newest: got %b %b %h want 0 1 80000500", inst_valid, arvalid, araddr);
        else n_pass++;
        mem_delay = 0;
        exp_pc    = 32'h8000_0500;
    endtask

    task automatic test_fetch_err();
        int unsigned cyc;
        bit ok;
        exp_t e;
        err_en   = 1'b1;
        err_addr = exp_pc;
        sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b1});
        sb_q.push_back('{inst: mem_word(exp_pc + 32'd4), pc: exp_pc + 32'd4, err: 1'b0});
        for (int k = 0; k < 2; k++) begin
            wait_valid(20, cyc, ok);
            e = sb_q.pop_front();
            n_checks++;
            if (!ok) $display("FAIL err_timeout: got no inst_valid want inst_valid");
            else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
                $display("FAIL err_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
            else n_pass++;
        end
        err_en = 1'b0;
        step();
        exp_pc = exp_pc + 32'd8;
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, exp_pc})
            $display("FAIL err_next: got %b %h want 1 %h", arvalid, araddr, exp_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_hold();
        int unsigned cyc;
        bit ok;
        exp_t e;
        inst_ready = 1'b0;
        sb_q.push_back('{inst: mem_word(exp_pc), pc: exp_pc, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL rh_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL rh_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'hFFFF_FFFC})
            $display("FAIL rh_priority: got %b %b %h want 0 1 fffffffc", inst_valid, arvalid, araddr);
        else n_pass++;
        sb_q.push_back('{inst: mem_word(32'hFFFF_FFFC), pc: 32'hFFFF_FFFC, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL wrap_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err} !== {e.inst, e.pc, e.err})
            $display("FAIL wrap_inst: got %h %h %b want %h %h %b", inst, inst_pc, fetch_err, e.inst, e.pc, e.err);
        else n_pass++;
        step();
        n_checks++;
        if ({arvalid, araddr} !== {1'b1, 32'h0000_0000})
            $display("FAIL wrap_next: got %b %h want 1 00000000", arvalid, araddr);
        else n_pass++;
        exp_pc = 32'h0000_0000;
    endtask

    task automatic test_reset_mid();
        int unsigned cyc;
        bit ok;
        exp_t e;
        mem_delay = 1;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({arvalid, rready, inst_valid} !== 3'b000)
            $display("FAIL rstmid_forced: got %b%b%b want 000", arvalid, rready, inst_valid);
        else n_pass++;
        step();
        rst       = 1'b0;
        mem_delay = 0;
        #1;
        n_checks++;
        if ({inst_valid, arvalid, araddr} !== {1'b0, 1'b1, RST_PC})
            $display("FAIL rstmid_restart: got %b %b %h want 0 1 %h", inst_valid, arvalid, araddr, RST_PC);
        else n_pass++;
        sb_q.push_back('{inst: 32'h0000_0413, pc: RST_PC, err: 1'b0});
        wait_valid(20, cyc, ok);
        e = sb_q.pop_front();
        n_checks++;
        if (!ok) $display("FAIL rstmid_timeout: got no inst_valid want inst_valid");
        else if ({inst, inst_pc, fetch_err, cyc} !== {e.inst, e.pc, e.err, 32'd2})
            $display("FAIL rstmid_inst: got %h %h %b lat %0d want %h %h %b lat 2",
                     inst, inst_pc, fetch_err, cyc, e.inst, e.pc, e.err);
        else n_pass++;
        step();
    endtask

    task automatic test_outstanding();
        n_checks++;
        if (overlap_cnt != 0) $display("FAIL outstanding: got %0d overlapping reads want 0", overlap_cnt);
        else n_pass++;
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
        else n_pass++;
    endtask

    initial begin
        rst            = 1'b1;
        arready        = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_pc         = RST_PC;
        test_reset();
        test_basic();
        test_throughput();
        test_hold_stall();
        test_redirect_wait();
        test_arready_stall();
        test_redirect_multi();
        test_fetch_err();
        test_redirect_hold();
        test_reset_mid();
        test_outstanding();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
